// File: rtl/rv32i_regbank_pkg.sv
// rtl/rv32i_regbank_pkg.sv - shared types and constants for the register bank controller
package rv32i_regbank_pkg;

  localparam int NREGS = 32;

  typedef logic [4:0] regidx_t;
  typedef logic [3:0] bankidx_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } ctrl_state_t;

  localparam regidx_t X0 = 5'd0;

endpackage

// File: rtl/rv32i_wb_arbiter.sv
// rtl/rv32i_wb_arbiter.sv - round-robin grant of the bank write port between execute and load
module rv32i_wb_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ex_valid_i,
  input  logic ex_block_i,
  input  logic ld_valid_i,
  output logic ex_gnt_o,
  output logic ld_gnt_o
);

  logic last_ld_q;
  logic ex_elig;
  logic ld_req;

  // A WAW-blocked execute request is not a contender, so it leaves last_ld untouched.
  always_comb begin
    ex_elig  = en_i && ex_valid_i && !ex_block_i;
    ld_req   = en_i && ld_valid_i;
    ld_gnt_o = ld_req && (!ex_elig || !last_ld_q);
    ex_gnt_o = ex_elig && (!ld_req || last_ld_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ld_q <= 1'b0;
    end else if (ex_elig && ld_req) begin
      last_ld_q <= ld_gnt_o;
    end
  end

endmodule

// File: rtl/rv32i_regbank_ctrl.sv
// rtl/rv32i_regbank_ctrl.sv - clear sweep, write-port scheduling and load scoreboard for the RV32I bank
module rv32i_regbank_ctrl
  import rv32i_regbank_pkg::*;
#(
  parameter int NREGS = rv32i_regbank_pkg::NREGS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  regidx_t     ex_rd_i,
  input  logic [31:0] ex_data_i,
  output logic        ex_ready_o,
  input  logic        ld_valid_i,
  input  regidx_t     ld_rd_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_ready_o,
  input  logic        ld_issue_i,
  input  regidx_t     ld_issue_rd_i,
  input  regidx_t     id_rs1_i,
  input  regidx_t     id_rs2_i,
  input  regidx_t     id_rd_i,
  input  logic        id_rd_valid_i,
  output logic        id_stall_o,
  output logic        init_done_o,
  output logic        rf_wen_o,
  output logic        rf_is_upper_o,
  output bankidx_t    rf_rd_16_o,
  output logic [31:0] rf_din_o,
  output bankidx_t    rf_rs1_16_o,
  output bankidx_t    rf_rs2_16_o
);

  ctrl_state_t      state_q;
  regidx_t          clr_idx_q;
  logic             init_done_q;
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             run;
  logic             ex_gnt;
  logic             ld_gnt;
  regidx_t          wb_rd;
  logic [31:0]      wb_data;

  assign run = (state_q == ST_RUN);

  rv32i_wb_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .en_i       (run),
    .ex_valid_i (ex_valid_i),
    .ex_block_i (pending_q[ex_rd_i]),
    .ld_valid_i (ld_valid_i),
    .ex_gnt_o   (ex_gnt),
    .ld_gnt_o   (ld_gnt)
  );

  always_comb begin
    ex_ready_o  = ex_gnt;
    ld_ready_o  = ld_gnt;
    init_done_o = init_done_q;
    rf_rs1_16_o = id_rs1_i[3:0];
    rf_rs2_16_o = id_rs2_i[3:0];
    wb_rd       = ld_gnt ? ld_rd_i : ex_rd_i;
    wb_data     = ld_gnt ? ld_data_i : ex_data_i;
    if (run) begin
      rf_wen_o      = (ex_gnt || ld_gnt) && (wb_rd != X0);
      rf_is_upper_o = wb_rd[4];
      rf_rd_16_o    = wb_rd[3:0];
      rf_din_o      = wb_data;
      id_stall_o    = pending_q[id_rs1_i] || pending_q[id_rs2_i] ||
                      (id_rd_valid_i && pending_q[id_rd_i]);
    end else begin
      rf_wen_o      = 1'b1;
      rf_is_upper_o = clr_idx_q[4];
      rf_rd_16_o    = clr_idx_q[3:0];
      rf_din_o      = 32'd0;
      id_stall_o    = 1'b1;
    end
  end

  // Clear is applied before set so an issue and a writeback to the same register leave it pending.
  always_comb begin
    pending_d = pending_q;
    if (ld_gnt) begin
      pending_d[ld_rd_i] = 1'b0;
    end
    if (run && ld_issue_i && (ld_issue_rd_i != X0)) begin
      pending_d[ld_issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_idx_q   <= 5'd1;
      init_done_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        ST_INIT: begin
          clr_idx_q <= clr_idx_q + 5'd1;
          if (clr_idx_q == 5'd31) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_regbank_ctrl.sv
// tb/tb_rv32i_regbank_ctrl.sv - directed vector bench for rv32i_regbank_ctrl
module tb_rv32i_regbank_ctrl;
  import rv32i_regbank_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  regidx_t     ex_rd = '0;
  logic [31:0] ex_data = '0;
  logic        ex_ready;
  logic        ld_valid = 1'b0;
  regidx_t     ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        ld_issue = 1'b0;
  regidx_t     ld_issue_rd = '0;
  regidx_t     id_rs1 = '0;
  regidx_t     id_rs2 = '0;
  regidx_t     id_rd = '0;
  logic        id_rd_valid = 1'b0;
  logic        id_stall;
  logic        init_done;
  logic        rf_wen;
  logic        rf_is_upper;
  bankidx_t    rf_rd_16;
  logic [31:0] rf_din;
  bankidx_t    rf_rs1_16;
  bankidx_t    rf_rs2_16;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv32i_regbank_ctrl #(.NREGS(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid_i    (ex_valid),
    .ex_rd_i       (ex_rd),
    .ex_data_i     (ex_data),
    .ex_ready_o    (ex_ready),
    .ld_valid_i    (ld_valid),
    .ld_rd_i       (ld_rd),
    .ld_data_i     (ld_data),
    .ld_ready_o    (ld_ready),
    .ld_issue_i    (ld_issue),
    .ld_issue_rd_i (ld_issue_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rd_i       (id_rd),
    .id_rd_valid_i (id_rd_valid),
    .id_stall_o    (id_stall),
    .init_done_o   (init_done),
    .rf_wen_o      (rf_wen),
    .rf_is_upper_o (rf_is_upper),
    .rf_rd_16_o    (rf_rd_16),
    .rf_din_o      (rf_din),
    .rf_rs1_16_o   (rf_rs1_16),
    .rf_rs2_16_o   (rf_rs2_16)
  );

  typedef struct {
    logic        ex_v;
    logic [4:0]  ex_r;
    logic [31:0] ex_d;
    logic        ld_v;
    logic [4:0]  ld_r;
    logic [31:0] ld_d;
    logic        iss;
    logic [4:0]  iss_r;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rdv;
    logic        e_exr;
    logic        e_ldr;
    logic        e_stall;
    logic        e_wen;
    logic        e_up;
    logic [3:0]  e_idx;
    logic [31:0] e_din;
  } vec_t;

  function automatic vec_t mk(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                              input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                              input logic is, input logic [4:0] ir,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                              input logic dv, input logic xr, input logic lrd, input logic st,
                              input logic w, input logic up, input logic [3:0] ix,
                              input logic [31:0] din);
    vec_t v;
    v.ex_v = ev; v.ex_r = er; v.ex_d = ed;
    v.ld_v = lv; v.ld_r = lr; v.ld_d = ld;
    v.iss = is; v.iss_r = ir;
    v.rs1 = s1; v.rs2 = s2; v.rd = d; v.rdv = dv;
    v.e_exr = xr; v.e_ldr = lrd; v.e_stall = st; v.e_wen = w;
    v.e_up = up; v.e_idx = ix; v.e_din = din;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_rd = '0; ex_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    ld_issue = 0; ld_issue_rd = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd_valid = 0;
  endtask

  // Called just after rst falls: checks all 31 clear writes, then the first RUN cycle.
  task automatic sweep_check(input string tag, input logic [4:0] probe_rs1);
    logic [4:0] exp_reg;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      exp_reg = 5'(i + 1);
      chk($sformatf("%s_sweep%0d", tag, i),
          64'({ex_ready, ld_ready, id_stall, init_done, rf_wen, rf_is_upper, rf_rd_16, rf_din}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, exp_reg, 32'd0}));
    end
    @(posedge clk);
    #1;
    idle_inputs();
    id_rs1 = probe_rs1;
    @(negedge clk);
    chk($sformatf("%s_done", tag),
        64'({init_done, id_stall, ex_ready, ld_ready, rf_wen}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(1,17,32'hDEADBEEF, 0,0,0,    0,0, 0,0,0,0,  1,0,0,1,1,4'h1,32'hDEADBEEF));
    tbl.push_back(mk(1,3,32'h33,        1,4,32'h44, 0,0, 0,0,0,0,  0,1,0,1,0,4'h4,32'h44));
    tbl.push_back(mk(1,3,32'h33,        1,4,32'h44, 0,0, 0,0,0,0,  1,0,0,1,0,4'h3,32'h33));
    tbl.push_back(mk(1,3,32'h33,        1,4,32'h44, 0,0, 0,0,0,0,  0,1,0,1,0,4'h4,32'h44));
    tbl.push_back(mk(1,3,32'h33,        1,4,32'h44, 0,0, 0,0,0,0,  1,0,0,1,0,4'h3,32'h33));
    tbl.push_back(mk(0,0,0,             0,0,0,    1,5, 0,0,0,0,  0,0,0,0,0,4'h0,32'h0));
    tbl.push_back(mk(1,5,32'h55,        0,0,0,    0,0, 0,5,0,0,  0,0,1,0,0,4'h5,32'h55));
    tbl.push_back(mk(1,5,32'h55,        1,5,32'hAA, 0,0, 0,5,0,0,  0,1,1,1,0,4'h5,32'hAA));
    tbl.push_back(mk(1,5,32'h55,        0,0,0,    0,0, 0,5,0,0,  1,0,0,1,0,4'h5,32'h55));
    tbl.push_back(mk(1,0,32'h1234,      0,0,0,    0,0, 0,0,0,0,  1,0,0,0,0,4'h0,32'h1234));
    tbl.push_back(mk(0,0,0,             1,9,32'h99, 1,9, 0,0,0,0,  0,1,0,1,0,4'h9,32'h99));
    tbl.push_back(mk(0,0,0,             0,0,0,    0,0, 0,0,9,0,  0,0,0,0,0,4'h0,32'h0));
    tbl.push_back(mk(0,0,0,             0,0,0,    0,0, 0,0,9,1,  0,0,1,0,0,4'h0,32'h0));
    tbl.push_back(mk(0,0,0,             1,9,32'h0, 1,7, 0,0,0,0,  0,1,0,1,0,4'h9,32'h0));
    tbl.push_back(mk(1,31,32'hF00D,     0,0,0,    0,0, 7,0,0,0,  1,0,1,1,1,4'hF,32'hF00D));
    tbl.push_back(mk(1,2,32'h22,        1,8,32'h88, 0,0, 0,7,23,1, 0,1,1,1,0,4'h8,32'h88));
    tbl.push_back(mk(1,7,32'h77,        0,0,0,    0,0, 0,0,7,1,  0,0,1,0,0,4'h7,32'h77));

    // Reset state, with requests and a load issue held to show they are ignored.
    idle_inputs();
    ex_valid = 1; ex_rd = 5'd5; ex_data = 32'h5;
    ld_valid = 1; ld_rd = 5'd6; ld_data = 32'h6;
    ld_issue = 1; ld_issue_rd = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        64'({ex_ready, ld_ready, id_stall, init_done, rf_wen, rf_is_upper, rf_rd_16, rf_din}),
        64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 32'd0}));
    @(posedge clk);
    #1;
    rst = 0;
    sweep_check("init", 5'd3);

    foreach (tbl[k]) begin
      @(posedge clk);
      #1;
      ex_valid = tbl[k].ex_v; ex_rd = tbl[k].ex_r; ex_data = tbl[k].ex_d;
      ld_valid = tbl[k].ld_v; ld_rd = tbl[k].ld_r; ld_data = tbl[k].ld_d;
      ld_issue = tbl[k].iss; ld_issue_rd = tbl[k].iss_r;
      id_rs1 = tbl[k].rs1; id_rs2 = tbl[k].rs2; id_rd = tbl[k].rd; id_rd_valid = tbl[k].rdv;
      @(negedge clk);
      chk($sformatf("vec%0d", k),
          64'({ex_ready, ld_ready, id_stall, rf_wen, rf_is_upper, rf_rd_16, rf_din,
               rf_rs1_16, rf_rs2_16}),
          64'({tbl[k].e_exr, tbl[k].e_ldr, tbl[k].e_stall, tbl[k].e_wen, tbl[k].e_up,
               tbl[k].e_idx, tbl[k].e_din, tbl[k].rs1[3:0], tbl[k].rs2[3:0]}));
    end

    // x7 is still pending here; an asynchronous reset must drop it and restart at x1.
    @(posedge clk);
    #1;
    idle_inputs();
    id_rs1 = 5'd7;
    @(negedge clk);
    chk("x7_pending_before_rst", 64'(id_stall), 64'(1'b1));
    #2;
    rst = 1;
    #1;
    chk("async_rst",
        64'({ex_ready, ld_ready, id_stall, init_done, rf_wen, rf_is_upper, rf_rd_16, rf_din}),
        64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 32'd0}));
    ex_valid = 1; ex_rd = 5'd5; ld_issue = 1; ld_issue_rd = 5'd7;
    @(posedge clk);
    #1;
    rst = 0;
    sweep_check("rerun", 5'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
